// File: rtl/soc_system_pulse_out.sv
// soc_system_pulse_out: Avalon-MM slave driving one pin with programmed pulse trains.
// Software programs high/low phase lengths and a pulse count, starts the train,
// and gets a sticky done flag. Build option: define PULSE_OUT_IRQ_EN to enable
// the MASK register and the done interrupt; otherwise irq is tied low and
// address 2 reads zero.
module soc_system_pulse_out (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        out_port
);

    localparam int unsigned LEN_W = 16;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [LEN_W-1:0]   high_len;
    logic [LEN_W-1:0]   low_len;
    logic [LEN_W-1:0]   phase_cnt;
    logic [LEN_W-1:0]   phase_cnt_next;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   remaining_next;
    logic               idle_level;
    logic               idle_level_next;
    logic               done;
    logic               done_next;
    logic               done_set;
    logic               out_next;
    logic [31:0]        read_mux;

    logic               wr_en;
    logic               wr_data;
    logic               wr_len;
    logic               wr_cmd;
    logic               cmd_abort;
    logic               cmd_clear;
    logic [CNT_W-1:0]   cmd_count;
    logic               busy;
    logic               start;
    logic               phase_done;
    logic [LEN_W-1:0]   high_load;
    logic [LEN_W-1:0]   low_load;

    // Bus decode and derived control terms
    assign wr_en      = chipselect & ~write_n;
    assign wr_data    = wr_en && (address == 2'd0);
    assign wr_len     = wr_en && (address == 2'd1);
    assign wr_cmd     = wr_en && (address == 2'd3);
    assign cmd_abort  = wr_cmd & writedata[31];
    assign cmd_clear  = wr_cmd & writedata[30];
    assign cmd_count  = writedata[CNT_W-1:0];
    assign busy       = (state != S_IDLE);
    assign start      = wr_cmd && !writedata[31] && (cmd_count != '0) && !busy;
    assign phase_done = (phase_cnt <= LEN_W'(1));
    // Zero-length phases are stretched to one cycle so every edge is visible
    assign high_load  = (high_len == '0) ? LEN_W'(1) : high_len;
    assign low_load   = (low_len  == '0) ? LEN_W'(1) : low_len;

`ifdef PULSE_OUT_IRQ_EN
    logic wr_mask;
    logic done_mask;
    logic done_mask_next;
    logic irq_next;

    assign wr_mask        = wr_en && (address == 2'd2);
    assign done_mask_next = wr_mask ? writedata[0] : done_mask;
    assign irq_next       = done_next & done_mask_next;

    // Interrupt mask register and registered level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_mask <= 1'b0;
            irq       <= 1'b0;
        end else begin
            done_mask <= done_mask_next;
            irq       <= irq_next;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_HIGH;
            S_HIGH: if (phase_done) state_next = S_LOW;
            S_LOW: begin
                if (phase_done) begin
                    state_next = (remaining > CNT_W'(1)) ? S_HIGH : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (cmd_abort) begin
            state_next = S_IDLE;
        end
    end

    // Output/datapath logic: phase counter, pulse count, done flag, pin level
    always_comb begin
        phase_cnt_next  = phase_cnt;
        remaining_next  = remaining;
        done_set        = 1'b0;
        idle_level_next = idle_level;
        out_next        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    phase_cnt_next = high_load;
                    remaining_next = cmd_count;
                end
            end
            S_HIGH: begin
                phase_cnt_next = phase_done ? low_load : phase_cnt - LEN_W'(1);
            end
            S_LOW: begin
                if (phase_done) begin
                    if (remaining > CNT_W'(1)) begin
                        phase_cnt_next = high_load;
                        remaining_next = remaining - CNT_W'(1);
                    end else begin
                        phase_cnt_next = '0;
                        remaining_next = '0;
                        done_set       = 1'b1;
                    end
                end else begin
                    phase_cnt_next = phase_cnt - LEN_W'(1);
                end
            end
            default: begin
                phase_cnt_next = '0;
                remaining_next = '0;
            end
        endcase

        if (cmd_abort) begin
            phase_cnt_next = '0;
            remaining_next = '0;
            done_set       = 1'b0;
        end

        if (wr_data && !busy) begin
            idle_level_next = writedata[0];
        end

        out_next = (state_next == S_HIGH) ? ~idle_level_next : idle_level_next;
    end

    // A new done event takes priority over a same-cycle clear request
    assign done_next = done_set ? 1'b1 : (cmd_clear ? 1'b0 : done);

    // Read mux over the current register contents
    always_comb begin
        read_mux = '0;
        case (address)
            2'd0: read_mux = {30'b0, busy, out_port};
            2'd1: read_mux = {low_len, high_len};
`ifdef PULSE_OUT_IRQ_EN
            2'd2: read_mux = {31'b0, done_mask};
`else
            2'd2: read_mux = '0;
`endif
            2'd3: read_mux = {16'b0, remaining, 6'b0, busy, done};
            default: read_mux = '0;
        endcase
    end

    // Datapath and bus registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_len   <= LEN_W'(1);
            low_len    <= LEN_W'(1);
            phase_cnt  <= '0;
            remaining  <= '0;
            idle_level <= 1'b0;
            done       <= 1'b0;
            out_port   <= 1'b0;
            readdata   <= '0;
        end else begin
            if (wr_len) begin
                high_len <= writedata[LEN_W-1:0];
                low_len  <= writedata[31:LEN_W];
            end
            phase_cnt  <= phase_cnt_next;
            remaining  <= remaining_next;
            idle_level <= idle_level_next;
            done       <= done_next;
            out_port   <= out_next;
            readdata   <= read_mux;
        end
    end

endmodule

// File: tb/tb_soc_system_pulse_out.sv
// Directed testbench for soc_system_pulse_out with hand-computed expectations.
module tb_soc_system_pulse_out;

`ifdef PULSE_OUT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        out_port;

    int checks   = 0;
    int failures = 0;

    soc_system_pulse_out dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    logic [31:0] rdat;
    logic [7:0]  rem;

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;

        // Reset values
        #12;
        chk("rst_out", {31'b0, out_port}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_rd", readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(2'd1, rdat);
        chk("rst_len", rdat, 32'h0001_0001);
        rd(2'd3, rdat);
        chk("rst_stat", rdat, 32'h0000_0000);

        // Timing: H=3, L=2, three pulses
        wr(2'd1, 32'h0002_0003);
        address = 2'd3;
        wr(2'd3, 32'h0000_0003);
        for (int i = 0; i <= 16; i++) begin
            if (i <= 15) chk("t_out", {31'b0, out_port}, (i < 15 && (i % 5) < 3) ? 32'd1 : 32'd0);
            if (i >= 1) begin
                rem = (i - 1 < 5) ? 8'd3 : (i - 1 < 10) ? 8'd2 : (i - 1 < 15) ? 8'd1 : 8'd0;
                chk("t_stat", readdata, {16'b0, rem, 6'b0, (i <= 15), (i == 16)});
            end
            if (i < 16) tick();
        end
        wr(2'd3, 32'h4000_0000);
        rd(2'd3, rdat);
        chk("t_clr", rdat, 32'h0000_0000);

        // Polarity and zero-length phases
        wr(2'd0, 32'h0000_0001);
        chk("p_idle", {31'b0, out_port}, 32'd1);
        wr(2'd1, 32'h0000_0000);
        address = 2'd3;
        wr(2'd3, 32'h0000_0001);
        chk("p_out0", {31'b0, out_port}, 32'd0);
        tick();
        chk("p_out1", {31'b0, out_port}, 32'd1);
        chk("p_st1", readdata, 32'h0000_0102);
        tick();
        chk("p_out2", {31'b0, out_port}, 32'd1);
        chk("p_st2", readdata, 32'h0000_0102);
        tick();
        chk("p_done", readdata, 32'h0000_0001);
        rd(2'd0, rdat);
        chk("p_data", rdat, 32'h0000_0001);
        wr(2'd3, 32'h4000_0000);

        // Abort mid-train, then abort+start together
        wr(2'd1, 32'h0004_0004);
        address = 2'd3;
        wr(2'd3, 32'h0000_0002);
        tick();
        tick();
        chk("a_pre", {31'b0, out_port}, 32'd0);
        wr(2'd3, 32'h8000_0000);
        chk("a_out", {31'b0, out_port}, 32'd1);
        tick();
        chk("a_stat", readdata, 32'h0000_0000);
        wr(2'd3, 32'h8000_0005);
        chk("a2_out0", {31'b0, out_port}, 32'd1);
        tick();
        chk("a2_out1", {31'b0, out_port}, 32'd1);
        chk("a2_stat", readdata, 32'h0000_0000);

        // Interrupt set, clear, and clear coinciding with done
        wr(2'd2, 32'h0000_0001);
        rd(2'd2, rdat);
        chk("i_mask", rdat, {31'b0, IRQ_ON});
        wr(2'd0, 32'h0000_0000);
        wr(2'd1, 32'h0000_0000);
        address = 2'd3;
        wr(2'd3, 32'h0000_0001);
        chk("i_pre", {31'b0, irq}, 32'd0);
        tick();
        tick();
        chk("i_set", {31'b0, irq}, {31'b0, IRQ_ON});
        rd(2'd3, rdat);
        chk("i_done", rdat, 32'h0000_0001);
        wr(2'd3, 32'h4000_0000);
        chk("i_clr", {31'b0, irq}, 32'd0);
        rd(2'd3, rdat);
        chk("i_clrst", rdat, 32'h0000_0000);
        wr(2'd3, 32'h0000_0001);
        tick();
        wr(2'd3, 32'h4000_0000);
        tick();
        chk("i_race", readdata, 32'h0000_0001);
        chk("i_rirq", {31'b0, irq}, {31'b0, IRQ_ON});
        wr(2'd3, 32'h4000_0000);

        // Writes while busy are ignored for count and idle level
        wr(2'd1, 32'h0002_0003);
        wr(2'd3, 32'h0000_0002);
        wr(2'd3, 32'h0000_0004);
        wr(2'd0, 32'h0000_0001);
        address = 2'd3;
        for (int i = 2; i <= 11; i++) begin
            if (i <= 10) chk("b_out", {31'b0, out_port}, (i < 10 && (i % 5) < 3) ? 32'd1 : 32'd0);
            if (i >= 3) begin
                rem = (i - 1 < 5) ? 8'd2 : (i - 1 < 10) ? 8'd1 : 8'd0;
                chk("b_stat", readdata, {16'b0, rem, 6'b0, (i <= 10), (i == 11)});
            end
            if (i < 11) tick();
        end
        rd(2'd0, rdat);
        chk("b_idle", rdat, 32'h0000_0000);
        chk("b_irq", {31'b0, irq}, {31'b0, IRQ_ON});

        // Reset asserted mid-train
        wr(2'd3, 32'h0000_0003);
        tick();
        chk("r_pre", {31'b0, out_port}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_out", {31'b0, out_port}, 32'd0);
        chk("r_irq", {31'b0, irq}, 32'd0);
        chk("r_rd", readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(2'd1, rdat);
        chk("r_len", rdat, 32'h0001_0001);
        rd(2'd3, rdat);
        chk("r_stat", rdat, 32'h0000_0000);
        tick();
        chk("r_out2", {31'b0, out_port}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
